// File: rtl/wb_ppi_gen.sv
// Wishbone parallel peripheral interface: up to 4 ports with per-bit direction,
// strobed input latching with IBF/OVR flags, and a programmable ack delay.

module wb_ppi_port #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] pin_s,
  input  logic [W-1:0] wdat,
  input  logic         stb_fall,
  input  logic         dat_we,
  input  logic         dir_we,
  input  logic         rd_clr,
  input  logic         lat_en,
  input  logic         lat_clr,
  input  logic         ovr_clr,
  output logic [W-1:0] out_q,
  output logic [W-1:0] dir_q,
  output logic [W-1:0] rd_val,
  output logic         ibf,
  output logic         ovr
);
  logic [W-1:0] in_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q <= '0;
      dir_q <= '0;
      in_q  <= '0;
      ibf   <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      if (dat_we) out_q <= wdat;
      if (dir_we) dir_q <= wdat;
      if (ovr_clr) ovr <= 1'b0;
      if (lat_clr) begin
        ibf <= 1'b0;
        ovr <= 1'b0;
      end else if (lat_en && stb_fall) begin
        // a clearing read on the same edge frees the buffer for the new strobe
        if (!ibf || rd_clr) begin
          in_q <= pin_s;
          ibf  <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end else if (rd_clr) begin
        ibf <= 1'b0;
      end
    end
  end

  assign rd_val = (dir_q & out_q) | (~dir_q & (lat_en ? in_q : pin_s));
endmodule

module wb_ppi_gen #(
  parameter int NPORTS   = 3,
  parameter int W        = 8,
  parameter int ACK_WAIT = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [3:0]            adr_i,
  input  logic [W-1:0]          dat_i,
  output logic [W-1:0]          dat_o,
  input  logic                  we_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  output logic                  ack_o,
  input  logic [NPORTS*W-1:0]   pin_i,
  output logic [NPORTS*W-1:0]   pin_o,
  output logic [NPORTS*W-1:0]   pin_oe,
  input  logic [NPORTS-1:0]     stb_n_i,
  output logic                  irq_o
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} st_t;

  st_t                       st;
  logic [1:0]                cnt;
  logic [3:0]                adr_q;
  logic                      we_q;
  logic [W-1:0]              dat_q;
  logic [NPORTS*W-1:0]       pin_s1, pin_s2;
  logic [NPORTS-1:0]         stb_s1, stb_s2, stb_d;
  logic [NPORTS-1:0]         lat_en, irq_en, ibf, ovr;
  logic [NPORTS-1:0][W-1:0]  out_q, dir_q, rd_val;
  logic [3:0]                lat4, irq4, ibf4, ovr4;
  logic                      accept, commit, c_we, c_rd, c_wr, ctrl_we, stat_we;
  logic [3:0]                c_adr;
  logic [W-1:0]              c_dat, rdata;

  // with no wait states the access commits on the accept edge, straight off the bus
  assign accept = (st == S_IDLE) && cyc_i && stb_i;
  assign commit = (accept && ACK_WAIT == 0) || (st == S_WAIT && cyc_i && cnt == 2'd1);
  assign c_adr  = (st == S_IDLE) ? adr_i : adr_q;
  assign c_we   = (st == S_IDLE) ? we_i  : we_q;
  assign c_dat  = (st == S_IDLE) ? dat_i : dat_q;
  assign c_rd   = commit && !c_we;
  assign c_wr   = commit && c_we;
  assign ctrl_we = c_wr && c_adr == 4'd8;
  assign stat_we = c_wr && c_adr == 4'd9;

  assign lat4 = 4'(lat_en);
  assign irq4 = 4'(irq_en);
  assign ibf4 = 4'(ibf);
  assign ovr4 = 4'(ovr);

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    wb_ppi_port #(.W(W)) u_port (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .pin_s    (pin_s2[p*W +: W]),
      .wdat     (c_dat),
      .stb_fall (stb_d[p] & ~stb_s2[p]),
      .dat_we   (c_wr && c_adr == 4'(p)),
      .dir_we   (c_wr && c_adr == 4'(p + 4)),
      .rd_clr   (c_rd && c_adr == 4'(p)),
      .lat_en   (lat_en[p]),
      .lat_clr  (ctrl_we && !c_dat[p]),
      .ovr_clr  (stat_we && c_dat[4+p]),
      .out_q    (out_q[p]),
      .dir_q    (dir_q[p]),
      .rd_val   (rd_val[p]),
      .ibf      (ibf[p]),
      .ovr      (ovr[p])
    );
  end

  assign pin_o  = out_q;
  assign pin_oe = dir_q;

  always_comb begin
    rdata = '0;
    case (c_adr)
      4'd8:    rdata[7:0] = {irq4, lat4};
      4'd9:    rdata[7:0] = {ovr4, ibf4};
      default: begin
        for (int p = 0; p < NPORTS; p++) begin
          if (c_adr == 4'(p))     rdata = rd_val[p];
          if (c_adr == 4'(p + 4)) rdata = dir_q[p];
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pin_s1 <= '0;
      pin_s2 <= '0;
      stb_s1 <= '0;
      stb_s2 <= '0;
      stb_d  <= '0;
      lat_en <= '0;
      irq_en <= '0;
      irq_o  <= 1'b0;
    end else begin
      pin_s1 <= pin_i;
      pin_s2 <= pin_s1;
      stb_s1 <= stb_n_i;
      stb_s2 <= stb_s1;
      stb_d  <= stb_s2;
      if (ctrl_we) begin
        lat_en <= c_dat[NPORTS-1:0];
        irq_en <= c_dat[4 +: NPORTS];
      end
      irq_o <= |(ibf & irq_en);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st    <= S_IDLE;
      cnt   <= '0;
      adr_q <= '0;
      we_q  <= 1'b0;
      dat_q <= '0;
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= commit;
      dat_o <= c_rd ? rdata : '0;
      case (st)
        S_IDLE: if (accept) begin
          adr_q <= adr_i;
          we_q  <= we_i;
          dat_q <= dat_i;
          cnt   <= 2'(ACK_WAIT);
          st    <= (ACK_WAIT == 0) ? S_ACK : S_WAIT;
        end
        S_WAIT: begin
          if (!cyc_i)          st  <= S_IDLE;
          else if (cnt == 2'd1) st <= S_ACK;
          else                 cnt <= cnt - 2'd1;
        end
        S_ACK:   st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_ppi_gen.sv
// Directed bench for wb_ppi_gen: bus tasks push expectations, an ack monitor
// pops and compares read data.

module tb_wb_ppi_gen;
  localparam int NP = 3, W = 8, AW = 2;

  logic            clk = 1'b0, rst;
  logic [3:0]      adr;
  logic [W-1:0]    dat_i, dat_o;
  logic            we, cyc, stb, ack, irq;
  logic [NP*W-1:0] pin_i, pin_o, pin_oe;
  logic [NP-1:0]   stb_n;
  int              n_cmp = 0, n_bad = 0, n_ack = 0;

  typedef struct {
    bit          rd;
    logic [7:0]  ev;
    string       nm;
  } exp_t;
  exp_t q[$];
  exp_t me;

  always #5 clk = ~clk;

  wb_ppi_gen #(.NPORTS(NP), .W(W), .ACK_WAIT(AW)) dut (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we), .cyc_i(cyc), .stb_i(stb), .ack_o(ack),
    .pin_i(pin_i), .pin_o(pin_o), .pin_oe(pin_oe), .stb_n_i(stb_n), .irq_o(irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ev);
    n_cmp++;
    if (act !== ev) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, ev);
    end
  endtask

  always @(negedge clk) begin
    if (ack === 1'b1) begin
      n_ack++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_ack: got ack expected none");
      end else begin
        me = q.pop_front();
        if (me.rd) chk(me.nm, {24'h0, dat_o}, {24'h0, me.ev});
      end
    end
  end

  task automatic bus(input logic [3:0] a, input logic w, input logic [7:0] d);
    int k = 0;
    adr = a; we = w; dat_i = d; cyc = 1'b1; stb = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (ack !== 1'b1 && k < 20);
    chk($sformatf("ack_latency_adr%0d", a), k, AW + 1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] ev, input string nm);
    q.push_back('{rd: 1'b1, ev: ev, nm: nm});
    bus(a, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    q.push_back('{rd: 1'b0, ev: 8'h00, nm: "wr"});
    bus(a, 1'b1, d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse0();
    stb_n[0] = 1'b0;
    idle(2);
    stb_n[0] = 1'b1;
    idle(4);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ack"},    {31'h0, ack}, 0);
    chk({nm, "_dat_o"},  {24'h0, dat_o}, 0);
    chk({nm, "_irq"},    {31'h0, irq}, 0);
    chk({nm, "_pin_o"},  {8'h0, pin_o}, 0);
    chk({nm, "_pin_oe"}, {8'h0, pin_oe}, 0);
  endtask

  initial begin
    int a0;
    rst = 1'b1; adr = '0; dat_i = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    stb_n = '1; pin_i = 24'h0000A5;
    idle(3);
    chk_all_zero("reset");
    rst = 1'b0;
    idle(2);

    rd(4'd4, 8'h00, "dir0_reset");
    rd(4'd0, 8'hA5, "data0_pins");

    wr(4'd4, 8'hF0);
    chk("pin_oe_f0", {24'h0, pin_oe[7:0]}, 32'hF0);
    pin_i[7:0] = 8'h0F;
    idle(3);
    wr(4'd0, 8'h3C);
    chk("pin_o_3c", {24'h0, pin_o[7:0]}, 32'h3C);
    rd(4'd0, 8'h3F, "data0_mixed");
    rd(4'd10, 8'h00, "unused_adr");
    rd(4'd3, 8'h00, "absent_port");

    wr(4'd4, 8'h00);
    wr(4'd8, 8'h11);
    rd(4'd8, 8'h11, "ctrl_rb");
    pin_i[7:0] = 8'h5A;
    idle(3);
    pulse0();
    pin_i[7:0] = 8'hFF;
    idle(3);
    chk("irq_set", {31'h0, irq}, 1);
    rd(4'd9, 8'h01, "stat_ibf");
    rd(4'd0, 8'h5A, "latched_5a");
    chk("irq_clr", {31'h0, irq}, 0);
    rd(4'd9, 8'h00, "stat_after_rd");

    pin_i[7:0] = 8'h11; idle(3); pulse0();
    pin_i[7:0] = 8'h22; idle(3); pulse0();
    rd(4'd9, 8'h11, "stat_ovr");
    wr(4'd9, 8'h10);
    rd(4'd9, 8'h01, "stat_w1c");
    rd(4'd0, 8'h11, "latch_kept");
    rd(4'd9, 8'h00, "stat_clear2");

    pin_i[7:0] = 8'h33; idle(3); pulse0();
    pin_i[7:0] = 8'h44; idle(3);
    stb_n[0] = 1'b0;
    rd(4'd0, 8'h33, "coinc_old");
    stb_n[0] = 1'b1;
    idle(4);
    rd(4'd9, 8'h01, "coinc_stat");
    rd(4'd0, 8'h44, "coinc_new");
    rd(4'd9, 8'h00, "coinc_stat2");

    a0 = n_ack;
    adr = 4'd0; we = 1'b1; dat_i = 8'h99; cyc = 1'b1; stb = 1'b1;
    idle(1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    idle(5);
    chk("abort_no_ack", n_ack, a0);
    chk("abort_pin_o", {24'h0, pin_o[7:0]}, 32'h3C);
    rd(4'd4, 8'h00, "after_abort");

    wr(4'd4, 8'hFF);
    pulse0();
    chk("irq_pre_rst", {31'h0, irq}, 1);
    a0 = n_ack;
    adr = 4'd0; we = 1'b1; dat_i = 8'h77; cyc = 1'b1; stb = 1'b1;
    idle(1);
    rst = 1'b1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(3);
    chk("rst_no_ack", n_ack, a0);
    chk_all_zero("midrst");
    rd(4'd0, 8'h44, "post_rst_pins");
    rd(4'd8, 8'h00, "post_rst_ctrl");

    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_ppi_gen.md
# wb_ppi_gen

Parametrised, native-Wishbone parallel peripheral interface. It is the successor to the legacy 8255 PPI behind its Wishbone wrapper. It provides 1–4 general-purpose ports of configurable width with per-bit direction control, optional strobed input latching with buffer-full/overrun flags and interrupt, and programmable acknowledge wait states. It sits on the internal Wishbone peripheral bus and drives board-level I/O pins.

## Interface
- `NPORTS`, default 3: number of ports, legal range 1..4.
- `W`, default 8: port width in bits, minimum 8.
- `ACK_WAIT`, default 0: extra wait cycles before `ack_o`, legal range 0..3.
- `clk_i` in 1: system clock. One clock; all logic runs on the rising edge.
- `rst_i` in 1: reset. Asynchronous and active-high.
- `adr_i` in 4: register address.
- `dat_i` in W: write data.
- `dat_o` out W: read data. Registered; valid while `ack_o`=1.
- `we_i` in 1: 1 = write, 0 = read.
- `cyc_i` in 1: bus cycle valid.
- `stb_i` in 1: strobe.
- `ack_o` out 1: one-cycle acknowledge.
- `pin_i` in NPORTS*W: port input pins. Port p occupies bits [p*W +: W].
- `pin_o` out NPORTS*W: output latches.
- `pin_oe` out NPORTS*W: per-bit output enable. Equals the direction register.
- `stb_n_i` in NPORTS: per-port active-low input strobe, asynchronous to `clk_i`.
- `irq_o` out 1: registered interrupt request.

## Operation
- Register map:
  - 0..3: DATA[p].
  - 4..7: DIR[p], 1 = output.
  - 8: CTRL. Bits [3:0] LAT_EN[p], bits [7:4] IRQ_EN[p].
  - 9: STAT. Bits [3:0] IBF[p], bits [7:4] OVR[p].
  - Unused bits read 0.
- Addresses of ports ≥ NPORTS, and addresses 10..15, read 0 and ignore writes. They are still acknowledged.
- Bus FSM states are IDLE, WAIT, ACK.
  - IDLE: on `cyc_i & stb_i`, latch `adr_i`/`we_i`/`dat_i` and go to WAIT (count = ACK_WAIT), or go straight to ACK if ACK_WAIT = 0.
  - WAIT: decrement the counter each cycle; go to ACK when it reaches 0.
  - ACK: `ack_o`=1 for exactly one cycle, then IDLE.
  - Writes and read side-effects commit on the edge that enters ACK.
  - `cyc_i` dropping in WAIT aborts the access: return to IDLE with no commit and no ack.
- Input path:
  - `pin_i` and `stb_n_i` pass through 2-flop synchronisers.
  - A falling edge on a synchronised `stb_n_i` is detected with one further register.
- DATA[p] read, per bit:
  - DIR = 1: returns the output latch.
  - DIR = 0 and LAT_EN[p] = 1: returns the input latch.
  - Otherwise: returns the synchronised pin.
- DATA[p] write updates the output latch for all bits, including bits currently set as inputs.
- Latch mode (LAT_EN[p] = 1), on a strobe falling edge:
  - If IBF[p] = 0: the input latch takes the synchronised pins and IBF[p] is set to 1.
  - If IBF[p] = 1: the latch is kept, OVR[p] is set to 1, IBF stays 1.
- Reading DATA[p] clears IBF[p].
  - If a strobe edge lands on the same edge as the clearing read: the latch updates, IBF[p] stays 1, OVR is not set.
- STAT write: OVR bits are write-1-to-clear. IBF bits ignore writes.
- Clearing LAT_EN[p] also clears IBF[p] and OVR[p].
- `irq_o` is registered: `|(IBF & IRQ_EN)` from the previous cycle.

## Timing
- Reset value of every output and register is 0: `ack_o`, `dat_o`, `irq_o`, `pin_o`, `pin_oe`, DIR, CTRL, STAT, all latches and synchronisers.
  - All ports come out of reset as inputs.
- Access accepted at edge T: `ack_o` is high in cycle T+1+ACK_WAIT.
  - The master holds its signals until ack.
  - The next access is accepted at the earliest on the edge after `ack_o` falls, so back-to-back accesses have 1 idle cycle.
- `pin_o`/`pin_oe` change on the ack edge of a DATA/DIR write.
- A pin change is visible to reads 2 edges later.
- A strobe falling edge sets IBF on the 3rd edge after it.
  - `irq_o` rises 1 edge after IBF.
  - `irq_o` falls 1 edge after the clearing read.
- Asserting `rst_i` mid-access forces IDLE immediately, drops `ack_o`, and commits nothing.

## Test plan
- Reset, then read DIR0 and DATA0 with `pin_i[7:0]`=8'hA5: `pin_oe`=0, reads return 8'h00 and 8'hA5. With ACK_WAIT = 2, `ack_o` appears 3 cycles after accept.
- Write DIR0=8'hF0, then DATA0=8'h3C with `pin_i`=8'h0F: `pin_o[7:0]`=8'h3C, `pin_oe`=8'hF0, DATA0 read = 8'h3F.
- CTRL=8'h11, `pin_i`=8'h5A, pulse `stb_n_i[0]` low, then change `pin_i` to 8'hFF: IBF0=1, `irq_o`=1. DATA0 read = 8'h5A, after which IBF0=0 and `irq_o` drops.
- Two strobes without an intervening read (8'h11, then 8'h22): STAT = 8'h11, DATA0 = 8'h11. Writing STAT=8'h10 then makes STAT = 8'h01.
- Strobe edge coincident with the clearing DATA0 read: IBF stays 1, OVR stays 0, a second read returns the new pin value.
- Drop `cyc_i` during WAIT of a DATA write, and separately assert `rst_i` mid-access: no ack and no latch change; after reset all outputs are 0.
